// File: rtl/biu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : biu_arb_pkg
//  Brief    : Shared types for the bus-interface-unit arbiter.
//  Revision : 1.0
// ============================================================================
package biu_arb_pkg;

    // Memory-port occupancy: IDLE = nothing outstanding, BUSY = response pending
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } biu_state_e;

    // Requester identity; also the encoding of the last-grant pointer
    typedef enum logic [0:0] {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

endpackage : biu_arb_pkg
`default_nettype wire

// File: rtl/biu_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter with grant lock held until accept.
//  Revision : 1.0
// ============================================================================
module rr_arb2
    import biu_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_req_if,
    input  logic    i_req_ls,
    input  logic    i_active,    // grant is being presented downstream
    input  logic    i_gnt_xfer,  // presented grant accepted this cycle
    output req_id_e o_gnt_id,
    output logic    o_gnt_vld
);

    req_id_e r_last;
    req_id_e r_lock_id;
    logic    r_locked;
    logic    w_use_lock;

    // A lock only sticks while its owner keeps requesting
    assign w_use_lock = r_locked & ((r_lock_id == REQ_IF) ? i_req_if : i_req_ls);
    assign o_gnt_vld  = i_req_if | i_req_ls;

    always_comb begin
        o_gnt_id = REQ_IF;
        if (w_use_lock) begin
            o_gnt_id = r_lock_id;
        end else if (i_req_if && i_req_ls) begin
            o_gnt_id = (r_last == REQ_IF) ? REQ_LS : REQ_IF;
        end else if (i_req_ls) begin
            o_gnt_id = REQ_LS;
        end else begin
            o_gnt_id = REQ_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= REQ_IF;
            r_lock_id <= REQ_IF;
            r_locked  <= 1'b0;
        end else if (i_gnt_xfer) begin
            r_last   <= o_gnt_id;
            r_locked <= 1'b0;
        end else if (i_active && o_gnt_vld) begin
            r_locked  <= 1'b1;
            r_lock_id <= o_gnt_id;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/biu_arb.sv
`default_nettype none
// ============================================================================
//  Module   : biu_arb
//  Brief    : Fetch / load-store arbiter onto a single-outstanding memory port.
//  Revision : 1.0
// ============================================================================
module biu_arb
    import biu_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic            clk,
    input  logic            rst,
    // fetch channel
    input  logic            if_req_vld,
    output logic            if_req_rdy,
    input  logic [AW-1:0]   if_req_pc,
    output logic            if_rsp_vld,
    input  logic            if_rsp_rdy,
    output logic [DW-1:0]   if_rsp_ir,
    // load/store channel
    input  logic            ls_req_vld,
    output logic            ls_req_rdy,
    input  logic [AW-1:0]   ls_req_addr,
    input  logic            ls_req_wr,
    input  logic [DW-1:0]   ls_req_wdata,
    input  logic [DW/8-1:0] ls_req_wstrb,
    output logic            ls_rsp_vld,
    input  logic            ls_rsp_rdy,
    output logic [DW-1:0]   ls_rsp_rdata,
    // shared memory port
    output logic            mem_req_vld,
    input  logic            mem_req_rdy,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wr,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wstrb,
    input  logic            mem_rsp_vld,
    output logic            mem_rsp_rdy,
    input  logic [DW-1:0]   mem_rsp_data
);

    localparam int c_SW = DW / 8;

    biu_state_e r_state;
    biu_state_e w_state_nxt;
    req_id_e    r_owner;
    req_id_e    w_gnt_id;
    logic       w_gnt_vld;
    logic       w_busy;
    logic       w_free;
    logic       w_req_xfer;
    logic       w_rsp_xfer;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .i_req_if   (if_req_vld),
        .i_req_ls   (ls_req_vld),
        .i_active   (mem_req_vld),
        .i_gnt_xfer (w_req_xfer),
        .o_gnt_id   (w_gnt_id),
        .o_gnt_vld  (w_gnt_vld)
    );

    // Response side: only the owner of the outstanding request sees it
    assign w_busy      = (r_state == BUSY);
    assign mem_rsp_rdy = w_busy & ((r_owner == REQ_IF) ? if_rsp_rdy : ls_rsp_rdy);
    assign w_rsp_xfer  = mem_rsp_vld & mem_rsp_rdy;
    assign if_rsp_vld  = mem_rsp_vld & w_busy & (r_owner == REQ_IF);
    assign ls_rsp_vld  = mem_rsp_vld & w_busy & (r_owner == REQ_LS);
    assign if_rsp_ir    = mem_rsp_data;
    assign ls_rsp_rdata = mem_rsp_data;

    // Port frees up in the same cycle the response drains, giving 1 txn/cycle
    assign w_free      = ~rst & (~w_busy | w_rsp_xfer);
    assign mem_req_vld = w_free & w_gnt_vld;
    assign w_req_xfer  = mem_req_vld & mem_req_rdy;
    assign if_req_rdy  = mem_req_vld & mem_req_rdy & (w_gnt_id == REQ_IF);
    assign ls_req_rdy  = mem_req_vld & mem_req_rdy & (w_gnt_id == REQ_LS);

    always_comb begin
        mem_req_addr  = if_req_pc;
        mem_req_wr    = 1'b0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (w_gnt_id == REQ_LS) begin
            mem_req_addr  = ls_req_addr;
            mem_req_wr    = ls_req_wr;
            mem_req_wdata = ls_req_wdata;
            mem_req_wstrb = ls_req_wstrb[c_SW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_xfer) w_state_nxt = BUSY;
            BUSY:    if (w_rsp_xfer && !w_req_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= REQ_IF;
        end else if (w_req_xfer) begin
            r_owner <= w_gnt_id;
        end
    end

endmodule : biu_arb
`default_nettype wire

// File: tb/tb_biu_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_biu_arb
//  Brief    : Directed and randomized self-checking bench for biu_arb.
//  Revision : 1.0
// ============================================================================
module tb_biu_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_vld, if_req_rdy, if_rsp_vld, if_rsp_rdy;
    logic [AW-1:0] if_req_pc;
    logic [DW-1:0] if_rsp_ir;
    logic          ls_req_vld, ls_req_rdy, ls_req_wr, ls_rsp_vld, ls_rsp_rdy;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata, ls_rsp_rdata;
    logic [SW-1:0] ls_req_wstrb;
    logic          mem_req_vld, mem_req_rdy, mem_req_wr, mem_rsp_vld, mem_rsp_rdy;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_data;
    logic [SW-1:0] mem_req_wstrb;

    always #5 clk = ~clk;

    biu_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req_vld(if_req_vld), .if_req_rdy(if_req_rdy), .if_req_pc(if_req_pc),
        .if_rsp_vld(if_rsp_vld), .if_rsp_rdy(if_rsp_rdy), .if_rsp_ir(if_rsp_ir),
        .ls_req_vld(ls_req_vld), .ls_req_rdy(ls_req_rdy), .ls_req_addr(ls_req_addr),
        .ls_req_wr(ls_req_wr), .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb),
        .ls_rsp_vld(ls_rsp_vld), .ls_rsp_rdy(ls_rsp_rdy), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_wr(mem_req_wr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding owners (0=fetch, 1=ld/st),
    // last granted requester, and requester held by an unaccepted offer (-1 none).
    int q_own[$];
    int m_last;
    int m_hold;
    bit x_if, x_ls, x_rsp;
    bit mem_pend;
    int mem_dly;

    task automatic model_reset();
        q_own.delete();
        m_last   = 0;
        m_hold   = -1;
        x_if     = 0;
        x_ls     = 0;
        x_rsp    = 0;
        mem_pend = 0;
        mem_dly  = 0;
    endtask

    task automatic clear_inputs();
        if_req_vld = 0; if_req_pc = '0; if_rsp_rdy = 0;
        ls_req_vld = 0; ls_req_addr = '0; ls_req_wr = 0; ls_req_wdata = '0; ls_req_wstrb = '0;
        ls_rsp_rdy = 0; mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = '0;
    endtask

    // Called at a negedge with inputs applied; checks, then advances one cycle.
    task automatic step();
        int own, w;
        bit own_rdy, e_rsp_x, e_free, e_mv, e_req_x;
        #1;
        own     = (q_own.size() != 0) ? q_own[0] : -1;
        own_rdy = (own == 0) ? if_rsp_rdy : (own == 1) ? ls_rsp_rdy : 1'b0;
        e_rsp_x = (own >= 0) && mem_rsp_vld && own_rdy;
        e_free  = !rst && ((own < 0) || e_rsp_x);
        if (m_hold >= 0 && ((m_hold == 0) ? if_req_vld : ls_req_vld)) w = m_hold;
        else if (if_req_vld && ls_req_vld) w = 1 - m_last;
        else if (ls_req_vld) w = 1;
        else if (if_req_vld) w = 0;
        else w = -1;
        e_mv    = e_free && (w >= 0);
        e_req_x = e_mv && mem_req_rdy;

        check("mem_req_vld", mem_req_vld, e_mv);
        check("if_req_rdy", if_req_rdy, e_req_x && (w == 0));
        check("ls_req_rdy", ls_req_rdy, e_req_x && (w == 1));
        check("mem_rsp_rdy", mem_rsp_rdy, (own >= 0) && own_rdy);
        check("if_rsp_vld", if_rsp_vld, (own == 0) && mem_rsp_vld);
        check("ls_rsp_vld", ls_rsp_vld, (own == 1) && mem_rsp_vld);
        if (e_mv && w == 0) begin
            check("mem_addr_if", mem_req_addr, if_req_pc);
            check("mem_wr_if", mem_req_wr, 1'b0);
            check("mem_wdata_if", mem_req_wdata, '0);
            check("mem_wstrb_if", mem_req_wstrb, '0);
        end
        if (e_mv && w == 1) begin
            check("mem_addr_ls", mem_req_addr, ls_req_addr);
            check("mem_wr_ls", mem_req_wr, ls_req_wr);
            check("mem_wdata_ls", mem_req_wdata, ls_req_wdata);
            check("mem_wstrb_ls", mem_req_wstrb, ls_req_wstrb);
        end
        if (own == 0 && mem_rsp_vld) check("if_rsp_ir", if_rsp_ir, mem_rsp_data);
        if (own == 1 && mem_rsp_vld) check("ls_rsp_rdata", ls_rsp_rdata, mem_rsp_data);

        x_if  = e_req_x && (w == 0);
        x_ls  = e_req_x && (w == 1);
        x_rsp = e_rsp_x;
        @(posedge clk);
        if (e_rsp_x) begin
            void'(q_own.pop_front());
            mem_pend = 0;
        end
        if (e_req_x) begin
            q_own.push_back(w);
            m_last   = w;
            m_hold   = -1;
            mem_pend = 1;
            mem_dly  = $urandom_range(0, 2);
        end else if (e_mv) begin
            m_hold = w;
        end
        @(negedge clk);
    endtask

    task automatic drive_rand();
        rst = 0;
        if ($urandom_range(0, 399) == 0) begin
            clear_inputs();
            rst = 1;
            model_reset();
            return;
        end
        if (x_if) if_req_vld = 0;
        if (!if_req_vld && $urandom_range(0, 1) == 1) begin
            if_req_vld = 1;
            if_req_pc  = $urandom;
        end
        if (x_ls) ls_req_vld = 0;
        if (!ls_req_vld && $urandom_range(0, 1) == 1) begin
            ls_req_vld   = 1;
            ls_req_addr  = $urandom;
            ls_req_wr    = 1'($urandom_range(0, 1));
            ls_req_wdata = $urandom;
            ls_req_wstrb = SW'($urandom);
        end
        if_rsp_rdy  = ($urandom_range(0, 3) != 0);
        ls_rsp_rdy  = ($urandom_range(0, 3) != 0);
        mem_req_rdy = ($urandom_range(0, 3) != 0);
        if (x_rsp) mem_rsp_vld = 0;
        if (mem_pend) begin
            if (mem_dly > 0) begin
                mem_dly--;
                mem_rsp_vld = 0;
            end else if (!mem_rsp_vld) begin
                mem_rsp_vld  = 1;
                mem_rsp_data = $urandom;
            end
        end else begin
            // stray responses with nothing outstanding must be ignored
            mem_rsp_vld  = ($urandom_range(0, 7) == 0);
            mem_rsp_data = $urandom;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        step();
        check("rst_mem_req_vld", mem_req_vld, 1'b0);
        rst = 0;

        // fetch only, 1-cycle memory latency
        if_req_vld = 1; if_req_pc = 32'h100; mem_req_rdy = 1; if_rsp_rdy = 1;
        #1 check("d034_addr", mem_req_addr, 32'h100);
        step();
        if_req_vld = 0; mem_rsp_vld = 1; mem_rsp_data = 32'h0000_0013;
        #1 check("d034_ir", if_rsp_ir, 32'h0000_0013);
        check("d034_ls_vld", ls_rsp_vld, 1'b0);
        step();
        mem_rsp_vld = 0;
        step();

        // simultaneous requests from reset: ld/st first, then fetch
        do_reset();
        if_req_vld = 1; if_req_pc = 32'h200;
        ls_req_vld = 1; ls_req_addr = 32'h2000; ls_req_wr = 1;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_wstrb = 4'hF;
        mem_req_rdy = 1; ls_rsp_rdy = 1; if_rsp_rdy = 1;
        #1 check("d035_ls_rdy", ls_req_rdy, 1'b1);
        check("d035_wr", mem_req_wr, 1'b1);
        check("d035_addr", mem_req_addr, 32'h2000);
        step();
        ls_req_addr = 32'h2004; mem_rsp_vld = 1; mem_rsp_data = 32'h1234_5678;
        #1 check("d035_if_rdy", if_req_rdy, 1'b1);
        check("d035_addr2", mem_req_addr, 32'h200);
        step();
        clear_inputs();

        // stalled fetch offer must not be preempted by a new ld/st request
        do_reset();
        if_req_vld = 1; if_req_pc = 32'h300; mem_req_rdy = 0;
        step();
        ls_req_vld = 1; ls_req_addr = 32'h4000; ls_req_wr = 0;
        #1 check("d036_c2_addr", mem_req_addr, 32'h300);
        step();
        step();
        mem_req_rdy = 1;
        #1 check("d036_c4_if_rdy", if_req_rdy, 1'b1);
        check("d036_c4_addr", mem_req_addr, 32'h300);
        step();
        if_req_vld = 0;

        // owner stalls response: port stays occupied
        mem_rsp_vld = 1; mem_rsp_data = 32'hCAFE_0001; if_rsp_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            #1 check("d037_rsp_rdy", mem_rsp_rdy, 1'b0);
            check("d037_req_vld", mem_req_vld, 1'b0);
            step();
        end
        if_rsp_rdy = 1;
        #1 check("d037_rsp_rdy_go", mem_rsp_rdy, 1'b1);
        check("d037_ls_rdy", ls_req_rdy, 1'b1);
        step();
        ls_req_vld = 0; mem_rsp_vld = 0;

        // reset while busy drops the outstanding transaction
        rst = 1;
        model_reset();
        step();
        rst = 0;
        mem_rsp_vld = 1; mem_rsp_data = 32'hBAD0_BAD0; ls_rsp_rdy = 1; if_rsp_rdy = 1;
        #1 check("d039_ls_vld", ls_rsp_vld, 1'b0);
        check("d039_if_vld", if_rsp_vld, 1'b0);
        step();
        mem_rsp_vld = 0; if_req_vld = 1; if_req_pc = 32'h500;
        #1 check("d039_req_vld", mem_req_vld, 1'b1);
        check("d039_addr", mem_req_addr, 32'h500);
        step();
        clear_inputs();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive_rand();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule : tb_biu_arb
`default_nettype wire

// File: doc/biu_arb.md
BIU_ARB -- requirements
Module: biu_arb

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; DW SHALL be a multiple of 8.
REQ-003 Clock and reset SHALL be one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  block clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_req_vld / if_req_rdy  input / output  1 / 1  fetch request handshake.
REQ-007 if_req_pc  input  AW  fetch address.
REQ-008 if_rsp_vld / if_rsp_rdy  output / input  1 / 1  fetch response handshake.
REQ-009 if_rsp_ir  output  DW  fetched instruction word.
REQ-010 ls_req_vld / ls_req_rdy  input / output  1 / 1  load/store request handshake.
REQ-011 ls_req_addr, ls_req_wr, ls_req_wdata, ls_req_wstrb  input  AW, 1, DW, DW/8  data address, write flag, write data, byte strobes.
REQ-012 ls_rsp_vld / ls_rsp_rdy  output / input  1 / 1  load/store response handshake.
REQ-013 ls_rsp_rdata  output  DW  load data.
REQ-014 mem_req_vld / mem_req_rdy  output / input  1 / 1  shared memory port request.
REQ-015 mem_req_addr, mem_req_wr, mem_req_wdata, mem_req_wstrb  output  AW, 1, DW, DW/8  muxed request payload; fetch drives wr=0, wdata=0, wstrb=0.
REQ-016 mem_rsp_vld / mem_rsp_rdy  input / output  1 / 1  shared memory port response.
REQ-017 mem_rsp_data  input  DW  response data.

Function
REQ-018 Transfer on any channel SHALL occur when vld and rdy are both high at a rising clk edge.
REQ-019 At most one memory transaction SHALL be outstanding; FSM states IDLE (no outstanding) and BUSY (request accepted, response pending).
REQ-020 IDLE->BUSY on mem request transfer; BUSY->IDLE on mem response transfer, unless a new mem request transfers in the same cycle (BUSY->BUSY).
REQ-021 Port is free when state==IDLE or a mem response transfers this cycle; mem_req_vld SHALL be asserted only while free.
REQ-022 Arbitration: if only one requester is valid it wins; if both are valid, winner is the one not granted last (round-robin, 1-bit last-grant pointer, reset value = fetch, so load/store wins first conflict).
REQ-023 Grant lock: once mem_req_vld is high for a winner without transfer, the same winner SHALL be held next cycle (locked register) until transfer; a newly valid other requester SHALL not preempt it.
REQ-024 Winner's req_rdy = free & mem_req_rdy; loser's req_rdy = 0; both 0 when not free.
REQ-025 An owner register SHALL record the winner on request transfer; response routed only to owner: owner rsp_vld = mem_rsp_vld & (state==BUSY); other rsp_vld = 0; mem_rsp_rdy = owner rsp_rdy & (state==BUSY).
REQ-026 if_rsp_ir and ls_rsp_rdata SHALL both be driven from mem_rsp_data (qualified only by rsp_vld).
REQ-027 mem_rsp_vld in IDLE SHALL be ignored (mem_rsp_rdy=0, no response forwarded).
REQ-028 Last-grant pointer SHALL update only on mem request transfer.
REQ-029 Request-to-mem latency 0 cycles (combinational mux); response-to-requester latency 0 cycles; sustained throughput one transaction per cycle when memory responds in the following cycle.

Reset
REQ-030 On rst: state=IDLE, owner=fetch, last-grant=fetch, lock=0; outputs mem_req_vld=0, if_rsp_vld=0, ls_rsp_vld=0, if_req_rdy=0, ls_req_rdy=0, mem_rsp_rdy=0.
REQ-031 Reset asserted mid-transaction SHALL discard the outstanding transaction; any mem response arriving afterward in IDLE is dropped per REQ-027.

Structure
REQ-032 Shared package SHALL hold the FSM state enum (IDLE, BUSY) and the requester-id enum (REQ_IF, REQ_LS).
REQ-033 Implementation SHALL use one sub-module, rr_arb2, containing the 2-way round-robin pointer and grant lock; FSM, owner and muxing remain in biu_arb.

Verification
REQ-034 Fetch only, pc=0x100, memory responds 1 cycle later with 0x00000013 -> if_rsp_ir=0x00000013, ls_rsp_vld never high.
REQ-035 Both valid from reset, ls addr=0x2000 wr=1 wdata=0xDEADBEEF wstrb=0xF -> ls granted first, mem_req_wr=1; next conflict grants fetch.
REQ-036 mem_req_rdy held low 3 cycles with fetch winning, ls_req_vld rises in cycle 2 -> mem_req_addr stays fetch pc, fetch transfers in cycle 4.
REQ-037 Response with owner rsp_rdy low 2 cycles -> mem_rsp_rdy low, no new mem_req_vld until response transfers.
REQ-038 Back-to-back fetches, memory 1-cycle latency -> new request transfers in same cycle as previous response, 1 transaction/cycle.
REQ-039 rst pulsed while BUSY, then mem_rsp_vld=1 -> all rsp_vld stay 0, next request arbitrated normally.
